// File: rtl/sram_ctrl_pkg.sv
// Shared types for the two-requester SRAM controller.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Requester index: 0 or 1
  typedef logic req_id_t;

  // One stage of the read-response tag pipeline
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/sram_rr_controller_arb.sv
// 2-way round-robin arbiter. prio_q names the requester that wins a
// contended cycle; it only moves when a grant is actually taken.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_id_t prio_q, prio_d;

  // Grant: a lone requester wins; on contention the prioritised one wins
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a transfer the other requester gets priority
  always_comb begin
    prio_d = prio_q;
    if (advance) prio_d = !gnt[1];
  end

  // Pointer register, requester 0 first after reset
  always_ff @(posedge clock) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/sram_rr_controller.sv
// Shares one single-port synchronous SRAM between two requesters:
// zero-fills the array after reset, then round-robin arbitrates and
// routes read data back to the requester that issued the read.
module sram_rr_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              mem_chip_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              chip_en_q, chip_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  tag_t [1:0]        tag_q, tag_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic       run;
  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       xfer;
  req_id_t    gid;

  // Requests are only visible to the arbiter in RUN and out of reset,
  // so req_ready is zero during INIT and while reset is held.
  assign run     = (state_q == ST_RUN) && !reset;
  assign arb_req = req_valid & {2{run}};
  assign xfer    = |(req_valid & gnt);
  assign gid     = gnt[1];

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (arb_req),
    .advance (xfer),
    .gnt     (gnt)
  );

  // Next-state: init sequencing, command register, read tag pipeline
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    chip_en_d   = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tag_d[0]    = '{valid: xfer && !req_wr[gid], id: gid};
    tag_d[1]    = tag_q[0];
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;

    // Memory data for tag_q[1] is valid now; capture it with its owner
    if (tag_q[1].valid) begin
      rsp_valid_d[tag_q[1].id] = 1'b1;
      rsp_data_d               = mem_rd_data;
    end

    case (state_q)
      ST_INIT: begin
        chip_en_d  = 1'b1;
        wr_en_d    = 1'b1;
        addr_d     = init_cnt_q;
        wdata_d    = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) begin
          chip_en_d = 1'b1;
          wr_en_d   = req_wr[gid];
          rd_en_d   = !req_wr[gid];
          addr_d    = gid ? req_addr1  : req_addr0;
          wdata_d   = gid ? req_wdata1 : req_wdata0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    init_done_d = (state_d == ST_RUN);
  end

  // State registers; reset clears outputs and flushes in-flight reads
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      chip_en_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      chip_en_q   <= chip_en_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready   = gnt;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign init_done   = init_done_q;
  assign mem_chip_en = chip_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_sram_rr_controller.sv
// Bench for sram_rr_controller: behavioural SRAM, shadow-array reference
// model with a due-cycle response queue, randomized traffic.
module tb_sram_rr_controller;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int             due;
    int             id;
    logic [DW-1:0]  dat;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b11;
  logic [1:0]    req_wr = 2'b00;
  logic [AW-1:0] req_addr0 = '0, req_addr1 = '0;
  logic [DW-1:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          init_done, mem_chip_en, mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;

  // second instance without the zero-fill
  logic          b_reset = 1'b1;
  logic [1:0]    b_valid = 2'b01;
  logic [1:0]    b_ready, b_rsp_valid;
  logic [DW-1:0] b_rsp_data;
  logic          b_init_done, b_chip_en, b_wr_en, b_rd_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wr_data;
  logic [DW-1:0] b_rd_data = '0;
  logic [AW-1:0] b_a0 = 10'h055;

  logic [DW-1:0] sram   [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  exp_t          rq[$];
  int            total = 0, bad = 0, cyc = 0, last_g = 1;

  always #5 clock = ~clock;

  // behavioural single-port SRAM, read data one cycle after sampling
  always @(posedge clock) begin
    if (mem_chip_en) begin
      if (mem_wr_en) sram[mem_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= sram[mem_addr];
    end
  end

  sram_rr_controller #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .init_done(init_done), .mem_chip_en(mem_chip_en),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  sram_rr_controller #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b0)) dut_b (
    .clock(clock), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_wr(2'b00), .req_addr0(b_a0), .req_addr1(10'h000),
    .req_wdata0(16'h0000), .req_wdata1(16'h0000), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .init_done(b_init_done), .mem_chip_en(b_chip_en),
    .mem_wr_en(b_wr_en), .mem_rd_en(b_rd_en), .mem_addr(b_addr),
    .mem_wr_data(b_wr_data), .mem_rd_data(b_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One RUN cycle: inputs already driven. Predict the grant from the
  // round-robin rule, update the shadow array / response queue, then
  // check the command and any response due after the edge.
  task automatic tick();
    logic [1:0]    eg;
    int            g;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    if (req_valid == 2'b11) eg = (last_g == 0) ? 2'b10 : 2'b01;
    else                    eg = req_valid;
    chk("ready", req_ready, eg);
    g = eg[1] ? 1 : 0;
    w = req_wr[g];
    a = g ? req_addr1 : req_addr0;
    d = g ? req_wdata1 : req_wdata0;
    if (eg != 2'b00) begin
      last_g = g;
      if (w) shadow[a] = d;
      else   rq.push_back('{cyc + 3, g, shadow[a]});
    end
    @(negedge clock);
    cyc++;
    chk("cmd_en", mem_chip_en, eg != 2'b00);
    if (eg != 2'b00) begin
      chk("cmd_rw", {mem_wr_en, mem_rd_en}, w ? 2'b10 : 2'b01);
      chk("cmd_addr", mem_addr, a);
      if (w) chk("cmd_wd", mem_wr_data, d);
    end
    if (rq.size() != 0 && rq[0].due == cyc) begin
      chk("rsp_vld", rsp_valid, 2'b01 << rq[0].id);
      chk("rsp_data", rsp_data, rq[0].dat);
      void'(rq.pop_front());
    end else begin
      chk("rsp_vld", rsp_valid, 2'b00);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v; req_wr = wr;
    req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = d0; req_wdata1 = d1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]   = 16'hDEAD;
      shadow[i] = '0;
    end

    // reset held: everything low even with requests pending
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_out", {rsp_valid, init_done, mem_chip_en, mem_wr_en, mem_rd_en}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("b_rst_ready", b_ready, 2'b00);
    chk("b_rst_done", b_init_done, 0);

    // zero-fill sequence; requests must be refused throughout
    reset = 1'b0;
    b_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk("init_en", {mem_chip_en, mem_wr_en, mem_rd_en}, 3'b110);
      chk("init_addr", mem_addr, i);
      chk("init_wd", mem_wr_data, 0);
      chk("init_done", init_done, i == DEPTH - 1);
      if (i < DEPTH - 1) chk("init_ready", req_ready, 2'b00);
      if (i == DEPTH - 2) req_valid = 2'b00;
      if (i == 0) begin
        chk("b_done", b_init_done, 1);
        chk("b_cmd", {b_chip_en, b_wr_en, b_rd_en}, 3'b101);
        chk("b_addr", b_addr, 10'h055);
        b_valid = 2'b00;
      end
    end

    @(negedge clock);
    cyc++;
    chk("idle_en", {mem_chip_en, mem_wr_en, mem_rd_en}, 3'b000);
    chk("idle_done", init_done, 1);
    chk("idle_ready", req_ready, 2'b00);

    // seed two addresses, one write from each requester
    drive(2'b01, 2'b11, 10'h001, 10'h002, 16'h1111, 16'h2222); tick();
    drive(2'b10, 2'b11, 10'h001, 10'h002, 16'h1111, 16'h2222); tick();

    // contention: grants alternate starting with requester 0
    drive(2'b11, 2'b00, 10'h001, 10'h002, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("alt_gnt", req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
    end

    // requester 1 alone wins every cycle, then requester 0 wins on joining
    drive(2'b10, 2'b00, 10'h001, 10'h002, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("solo1", req_ready, 2'b10);
      tick();
    end
    req_valid = 2'b11;
    #1 chk("join0", req_ready, 2'b01);
    tick();

    // write then immediately read the same address, plus untouched 0x3FF
    drive(2'b01, 2'b01, 10'h012, 10'h000, 16'hA5A5, 16'h0); tick();
    drive(2'b01, 2'b00, 10'h012, 10'h000, 16'h0, 16'h0);    tick();
    drive(2'b01, 2'b00, 10'h3FF, 10'h000, 16'h0, 16'h0);    tick();
    req_valid = 2'b00;
    tick();
    chk("a5_seen", rsp_valid, 2'b01);
    chk("a5_data", rsp_data, 16'hA5A5);
    for (int i = 0; i < 3; i++) tick();
    chk("drain1", rq.size(), 0);

    // randomized traffic on a small address window to exercise hazards
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 2'($urandom), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), DW'($urandom), DW'($urandom));
      tick();
    end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    chk("drain2", rq.size(), 0);

    // reset with a read one stage in flight: response must vanish
    drive(2'b01, 2'b00, 10'h012, 10'h000, 16'h0, 16'h0);
    tick();
    rq.delete();
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clock);
    chk("mid_rst_out", {req_ready, rsp_valid, init_done, mem_chip_en, mem_wr_en, mem_rd_en}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", rsp_data, 0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk("reinit_rsp", rsp_valid, 2'b00);
      chk("reinit_addr", mem_addr, i);
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    last_g = 1;
    @(negedge clock);
    cyc++;
    chk("reinit_done", init_done, 1);

    // memory is cleared again after the second fill
    drive(2'b10, 2'b00, 10'h000, 10'h012, 16'h0, 16'h0); tick();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    chk("drain3", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_rr_controller.md
Name: sram_rr_controller

Overview:
- Sequences and shares one single-port synchronous SRAM (MemGen_16_10 class: 1024 x 16, one access per cycle, read data valid the cycle after the access is sampled) between two requesters.
- After reset it zero-initialises the whole array, then round-robin arbitrates read/write requests and returns read data to the originating requester.
- Sits between client logic and the submodule-level memory wrapper.
- Drives chip_en, wr_en, rd_en, addr and wr_data.

Parameters:
- ADDR_W, 10, memory address width; depth = 2**ADDR_W.
- DATA_W, 16, memory data width.
- INIT_EN, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready at a clock edge.
- req_wr  in  2  1 = write, 0 = read, per requester.
- req_addr0, req_addr1  in  ADDR_W each  request address.
- req_wdata0, req_wdata1  in  DATA_W each  write data.
- rsp_valid  out  2  one-cycle read-response strobe per requester.
- rsp_data  out  DATA_W  read data, qualified by rsp_valid.
- init_done  out  1  high once the array is cleared (and in RUN).
- mem_chip_en  out  1  memory chip enable.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data.

Behaviour:
- Reset (synchronous, any state):
  - All outputs go to 0: req_ready, rsp_valid, rsp_data, init_done and all mem_* are 0.
  - Init counter = 0; round-robin pointer = requester 0.
  - The in-flight tag pipeline is flushed. Responses for requests accepted before reset are never delivered.
- FSM states: INIT, RUN.
  - Leaving reset: INIT if INIT_EN = 1, else RUN.
- INIT state:
  - req_ready = 0.
  - Every cycle, register a write of 0 to address init_cnt: mem_chip_en = 1, mem_wr_en = 1, mem_rd_en = 0.
  - init_cnt increments.
  - After the write to address 2**ADDR_W-1 is issued, move to RUN. Total length is 1024 cycles at default parameters.
  - init_done rises in the first RUN cycle and stays high until reset.
- RUN state, arbitration (sub-module rr_arb2):
  - req_ready is combinational from req_valid and the pointer; at most one bit is set.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - The pointer updates only on an actual transfer. With no transfer, the pointer holds.
  - req_ready never depends on req_ready (no loop).
- Command stage:
  - A transfer at edge E0 registers the command onto mem_* during the next cycle (sampled by the memory at E1).
  - mem_chip_en = 1, mem_wr_en = req_wr, mem_rd_en = !req_wr, plus addr and data of the granted requester.
  - With no transfer, all mem_* enables are 0. addr and wr_data hold their previous values.
- Read response:
  - The memory drives mem_rd_data after E1. The controller registers it into rsp_data at E2.
  - rsp_valid[id] is high for exactly the cycle after E2. Read latency = 2 edges from acceptance.
  - A 2-stage id/valid tag pipeline carries the requester id.
  - Writes produce no response.
- Throughput: one accepted request per cycle. Back-to-back reads give back-to-back responses.
- Hazards:
  - A read accepted in the cycle after a write to the same address returns the new data, because the write is committed at the memory edge before the read is sampled.
  - No forwarding logic.
- Responses have no backpressure. Requesters must always sink rsp_valid.
- Width rules: addresses wrap naturally at 2**ADDR_W. No range checking.

Decomposition:
- Package sram_ctrl_pkg:
  - ADDR_W and DATA_W defaults.
  - State enum {ST_INIT, ST_RUN}.
  - Requester id type (1 bit).
  - Tag struct {valid, id}.
- Sub-module rr_arb2:
  - 2-way round-robin arbiter: req[1:0], advance, gnt[1:0], last pointer register.
  - Instantiated once.
- The memory itself remains outside this block.

Test Plan:
- Reset, then idle: init_done = 0 for 1024 cycles. mem_wr_en = 1 with mem_addr 0..1023 and mem_wr_data = 0. Then init_done = 1, all mem_* enables = 0, req_ready = 0 with no request.
- Requester 0 writes 0xA5A5 to 0x012; the next cycle it reads 0x012. Required: rsp_valid = 2'b01 with rsp_data = 0xA5A5 exactly 2 edges after the read is accepted. A read of untouched 0x3FF returns 0x0000.
- Both requesters hold valid reads (0x001, 0x002) for 4 cycles. Required: grants alternate 0,1,0,1 (starting with requester 0 after reset). rsp_valid alternates 01,10,01,10 with the matching data.
- Only requester 1 is valid for 3 cycles. Required: granted every cycle. When requester 0 then joins, requester 0 wins next.
- Assert reset for one cycle while a read is one stage in flight. Required: no rsp_valid afterwards, all outputs 0, INIT restarts at address 0.
- INIT_EN = 0: init_done = 1 in the first cycle after reset, and a request is accepted immediately.
